// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, derived totals, sync windows and phase encodings.
// Horizontal units are XPos counts (two per pixel); vertical units are lines.
package vga_timing_pkg;

    localparam int H_VISIBLE_D = 1280;
    localparam int H_FRONT_D   = 32;
    localparam int H_SYNC_D    = 192;
    localparam int H_BACK_D    = 96;
    localparam int V_VISIBLE_D = 480;
    localparam int V_FRONT_D   = 10;
    localparam int V_SYNC_D    = 2;
    localparam int V_BACK_D    = 33;
    localparam int PIPE_DLY_D  = 2;

    localparam int H_TOTAL = H_VISIBLE_D + H_FRONT_D + H_SYNC_D + H_BACK_D;
    localparam int V_TOTAL = V_VISIBLE_D + V_FRONT_D + V_SYNC_D + V_BACK_D;

    // Inclusive low windows of the undelayed sync signals
    localparam int HS_FIRST = H_VISIBLE_D + H_FRONT_D;
    localparam int HS_LAST  = HS_FIRST + H_SYNC_D - 1;
    localparam int VS_FIRST = V_VISIBLE_D + V_FRONT_D;
    localparam int VS_LAST  = VS_FIRST + V_SYNC_D - 1;

    typedef enum logic [1:0] {H_ACT, H_FP, H_SYN, H_BP} h_phase_e;
    typedef enum logic [1:0] {V_ACT, V_FP, V_SYN, V_BP} v_phase_e;

endpackage

// File: rtl/vga_sync_delay.sv
// Enabled shift register that lines {hsync, vsync} up with the pixel pipeline.
// Reset presets every stage to 1 so no stale low sync bit can emerge later.
module vga_sync_delay #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    logic [DEPTH-1:0][1:0] sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '1;
        end else if (enable) begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster counters, horizontal/vertical phase trackers, delayed syncs and
// frame_start / snap_en pulses. The counters are the source of truth.
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_D,
    parameter int H_FRONT   = H_FRONT_D,
    parameter int H_SYNC    = H_SYNC_D,
    parameter int H_BACK    = H_BACK_D,
    parameter int V_VISIBLE = V_VISIBLE_D,
    parameter int V_FRONT   = V_FRONT_D,
    parameter int V_SYNC    = V_SYNC_D,
    parameter int V_BACK    = V_BACK_D,
    parameter int PIPE_DLY  = PIPE_DLY_D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [10:0] XPos,
    output logic [9:0]  YPos,
    output logic        Valid,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        snap_en
);

    localparam logic [10:0] H_ACT_LAST = 11'(H_VISIBLE - 1);
    localparam logic [10:0] H_FP_LAST  = 11'(H_VISIBLE + H_FRONT - 1);
    localparam logic [10:0] H_SYN_LAST = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] X_LAST     = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0]  V_ACT_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0]  V_FP_LAST  = 10'(V_VISIBLE + V_FRONT - 1);
    localparam logic [9:0]  V_SYN_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0]  Y_LAST     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] X_VIS      = 11'(H_VISIBLE);
    localparam logic [9:0]  Y_VIS      = 10'(V_VISIBLE);

    h_phase_e h_state, h_next;
    v_phase_e v_state, v_next;
    logic     line_end, frame_end;
    logic     hs_raw, vs_raw;
    logic     fs_q, snap_q;

    assign line_end  = (XPos == X_LAST);
    assign frame_end = line_end && (YPos == Y_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            XPos <= '0;
            YPos <= '0;
        end else if (enable) begin
            XPos <= line_end ? 11'd0 : XPos + 11'd1;
            if (line_end) YPos <= (YPos == Y_LAST) ? 10'd0 : YPos + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_state <= H_ACT;
            v_state <= V_ACT;
        end else begin
            h_state <= h_next;
            v_state <= v_next;
        end
    end

    always_comb begin
        h_next = h_state;
        if (enable) begin
            case (h_state)
                H_ACT:   if (XPos == H_ACT_LAST) h_next = H_FP;
                H_FP:    if (XPos == H_FP_LAST)  h_next = H_SYN;
                H_SYN:   if (XPos == H_SYN_LAST) h_next = H_BP;
                H_BP:    if (XPos == X_LAST)     h_next = H_ACT;
                default: h_next = H_ACT;
            endcase
        end
    end

    always_comb begin
        v_next = v_state;
        if (enable && line_end) begin
            case (v_state)
                V_ACT:   if (YPos == V_ACT_LAST) v_next = V_FP;
                V_FP:    if (YPos == V_FP_LAST)  v_next = V_SYN;
                V_SYN:   if (YPos == V_SYN_LAST) v_next = V_BP;
                V_BP:    if (YPos == Y_LAST)     v_next = V_ACT;
                default: v_next = V_ACT;
            endcase
        end
    end

    // Pulses are registered off the wrap so the post-reset (0,0) never fires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_q   <= 1'b0;
            snap_q <= 1'b0;
        end else begin
            fs_q   <= enable && frame_end;
            snap_q <= enable && line_end && (YPos == V_ACT_LAST);
        end
    end

    assign frame_start = fs_q && enable;
    assign snap_en     = snap_q && enable;

    assign Valid  = (XPos < X_VIS) && (YPos < Y_VIS);
    assign hs_raw = !((XPos > H_FP_LAST) && (XPos <= H_SYN_LAST));
    assign vs_raw = !((YPos > V_FP_LAST) && (YPos <= V_SYN_LAST));

    vga_sync_delay #(.DEPTH(PIPE_DLY)) u_sync_delay (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .din    ({hs_raw, vs_raw}),
        .dout   ({hsync, vsync})
    );

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: a default-timing instance for line-level checks and a
// shrunken-timing instance (24 x 10 counts) for whole-frame checks.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    logic reset, enable;
    int   nvec = 0;
    int   nerr = 0;

    logic [10:0] d_x, s_x;
    logic [9:0]  d_y, s_y;
    logic d_valid, d_hs, d_vs, d_fs, d_snap;
    logic s_valid, s_hs, s_vs, s_fs, s_snap;

    always #5 clk = ~clk;

    vga_timing_ctrl u_dut (
        .clk(clk), .reset(reset), .enable(enable),
        .XPos(d_x), .YPos(d_y), .Valid(d_valid), .hsync(d_hs), .vsync(d_vs),
        .frame_start(d_fs), .snap_en(d_snap)
    );

    vga_timing_ctrl #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .PIPE_DLY(2)
    ) u_small (
        .clk(clk), .reset(reset), .enable(enable),
        .XPos(s_x), .YPos(s_y), .Valid(s_valid), .hsync(s_hs), .vsync(s_vs),
        .frame_start(s_fs), .snap_en(s_snap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs_low, hs_fall, hs_rise, d_fs_cnt;
        int s_vld_cnt, s_vs_low, s_fs_cnt, s_snap_cnt, s_snap_x, s_snap_y, s_snap_vld, s_ymax;
        int frz_bad, post_bad;
        logic prev_hs;

        reset = 1'b1;
        enable = 1'b0;
        #3;
        chk("reset_x", d_x, 0);
        chk("reset_y", d_y, 0);
        chk("reset_syncs", {d_hs, d_vs}, 2'b11);
        chk("reset_pulses", {d_fs, d_snap}, 2'b00);
        chk("reset_valid", d_valid, 1);
        step();
        step();
        reset = 1'b0;
        enable = 1'b1;

        hs_low = 0; hs_fall = -1; hs_rise = -1; d_fs_cnt = 0; prev_hs = 1'b1;
        s_vld_cnt = 0; s_vs_low = 0; s_fs_cnt = 0; s_snap_cnt = 0;
        s_snap_x = -1; s_snap_y = -1; s_snap_vld = 0; s_ymax = 0;
        for (int i = 1; i <= 1600; i++) begin
            step();
            if (i == 1) begin
                chk("first_x", d_x, 1);
                chk("first_no_fs", d_fs, 0);
            end
            if (!d_hs) hs_low++;
            if (prev_hs && !d_hs) hs_fall = d_x;
            if (!prev_hs && d_hs) hs_rise = d_x;
            prev_hs = d_hs;
            if (d_fs) d_fs_cnt++;
            if (i <= 240) begin
                if (s_valid) s_vld_cnt++;
                if (!s_vs) s_vs_low++;
                if (s_fs) s_fs_cnt++;
                if (s_snap) begin
                    s_snap_cnt++;
                    s_snap_x = s_x;
                    s_snap_y = s_y;
                    if (s_valid) s_snap_vld++;
                end
                if (s_y > s_ymax) s_ymax = s_y;
            end
            if (i == 240) begin
                chk("small_wrap_xy", {s_x, 6'd0, s_y}, 0);
                chk("small_wrap_fs", s_fs, 1);
            end
        end
        chk("line_x", d_x, 0);
        chk("line_y", d_y, 1);
        chk("hs_low_cnt", hs_low, 192);
        chk("hs_fall_x", hs_fall, 1314);
        chk("hs_rise_x", hs_rise, 1506);
        chk("no_fs_line", d_fs_cnt, 0);
        chk("frame_valid_cnt", s_vld_cnt, 96);
        chk("frame_vs_low", s_vs_low, 24);
        chk("frame_fs_cnt", s_fs_cnt, 1);
        chk("frame_snap_cnt", s_snap_cnt, 1);
        chk("snap_xy", {s_snap_x[15:0], s_snap_y[15:0]}, {16'd0, 16'd6});
        chk("snap_not_valid", s_snap_vld, 0);
        chk("small_ymax", s_ymax, 9);

        for (int i = 0; i < 1400; i++) step();
        chk("pre_freeze_x", d_x, 1400);
        chk("pre_freeze_hs", d_hs, 0);
        enable = 1'b0;
        frz_bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (d_x !== 11'd1400 || d_hs !== 1'b0 || d_fs || d_snap || s_fs || s_snap) frz_bad++;
        end
        chk("freeze_hold", frz_bad, 0);
        enable = 1'b1;
        step();
        chk("resume_x", d_x, 1401);

        #2;
        reset = 1'b1;
        #1;
        chk("midsync_rst_hs", d_hs, 1);
        chk("midsync_rst_x", d_x, 0);
        step();
        reset = 1'b0;
        post_bad = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (!d_hs || !d_vs) post_bad++;
        end
        chk("no_stale_sync", post_bad, 0);
        chk("post_rst_x", d_x, 300);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter H_VISIBLE, default 1280: visible XPos counts per line (2 counts per pixel).
REQ-002 Parameter H_FRONT, default 32: horizontal front porch counts.
REQ-003 Parameter H_SYNC, default 192: horizontal sync width counts.
REQ-004 Parameter H_BACK, default 96: horizontal back porch counts; line total is 1600.
REQ-005 Parameter V_VISIBLE / V_FRONT / V_SYNC / V_BACK, defaults 480 / 10 / 2 / 33: lines; frame total is 525.
REQ-006 Parameter PIPE_DLY, default 2: cycles of latency in the downstream character pipeline.
REQ-007 clk  input  1  single clock; every register updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 enable  input  1  advances the counters when high; freezes all state when low.
REQ-010 XPos  output  11  horizontal count, 0..1599.
REQ-011 YPos  output  10  vertical line, 0..524.
REQ-012 Valid  output  1  high while XPos < H_VISIBLE and YPos < V_VISIBLE.
REQ-013 hsync / vsync  output  1 each  active-low sync outputs, delayed by PIPE_DLY.
REQ-014 frame_start  output  1  one-cycle pulse when XPos = 0 and YPos = 0.
REQ-015 snap_en  output  1  one-cycle pulse that downstream CPU-state registers use to capture a tear-free frame snapshot.

Function
REQ-016 When enable = 1, XPos shall increment by 1 each cycle and wrap from 1599 to 0.
REQ-017 On the XPos 1599->0 wrap, YPos shall increment, and YPos shall wrap from 524 to 0 on that same cycle.
REQ-018 When enable = 0, XPos, YPos, the phase registers and the delay pipeline shall hold, and frame_start and snap_en shall be 0.
REQ-019 Valid shall be combinational from the registered counters, with zero latency relative to XPos and YPos.
REQ-020 The undelayed hsync shall be low for XPos in [1312, 1503]; the undelayed vsync shall be low for YPos in [490, 491].
REQ-021 hsync and vsync shall equal the undelayed values delayed by exactly PIPE_DLY enabled cycles, so sync aligns with the registered pixel color.
REQ-022 A horizontal state machine shall track the phases H_ACT -> H_FP -> H_SYN -> H_BP -> H_ACT, with transitions at XPos = 1279, 1311, 1503 and 1599.
REQ-023 A vertical state machine with states V_ACT, V_FP, V_SYN and V_BP shall advance only on the line wrap, with transitions at YPos = 479, 489, 491 and 524.
REQ-024 State encodings shall always agree with the counter ranges; the counters are authoritative, and any disagreement is a bug.
REQ-025 snap_en shall pulse for one cycle at XPos = 0, YPos = 480 (start of vertical blank), never during Valid.
REQ-026 frame_start shall be registered and asserted in the cycle in which the counters read (0, 0).
REQ-027 Counter compares shall use the full counter width; there shall be no truncation at 1599 or 524.

Reset
REQ-028 Asserting reset shall immediately force the following, independent of clk:
  - XPos = 0, YPos = 0;
  - both state machines to H_ACT / V_ACT;
  - delay pipeline filled with 1s, so hsync = 1 and vsync = 1;
  - frame_start = 0, snap_en = 0.
REQ-029 On the first enabled edge after reset deasserts, XPos shall become 1; frame_start shall not pulse for the post-reset (0, 0).
REQ-030 Reset asserted mid-line or mid-sync shall abort the sync pulse immediately, with no partial pulse completing from the delay pipeline.

Structure
REQ-031 Package vga_timing_pkg shall hold:
  - the default timing constants;
  - the derived totals H_TOTAL = 1600 and V_TOTAL = 525;
  - the hsync/vsync window bounds;
  - the H/V phase-state enumerations.
REQ-032 One sub-module, vga_sync_delay, shall be a PIPE_DLY-deep, 2-bit-wide shift register with enable and asynchronous preset-to-1.
REQ-033 Counters, state machines and pulse logic shall reside in vga_timing_ctrl, for an estimated 150-250 lines of RTL in total.

Verification
REQ-034 Reset, then enable = 1 for 1600 cycles -> XPos returns to 0, YPos = 1, and exactly one undelayed hsync low window of 192 cycles occurs, starting at XPos = 1312.
REQ-035 Run one full frame (840000 cycles) -> Valid high for exactly 614400 cycles, vsync low for 3200 cycles, one frame_start pulse, one snap_en pulse at (0, 480).
REQ-036 At (1599, 524) with enable = 1 -> next cycle is (0, 0) and frame_start = 1; YPos never reads 525.
REQ-037 Drop enable for 10 cycles at XPos = 1400 -> XPos stays 1400, hsync holds its value, no pulses; resumes at 1401.
REQ-038 Assert reset at XPos = 1400 (inside hsync) -> hsync = 1 and XPos = 0 before the next edge; after release, no delayed low sync bit emerges.
REQ-039 With PIPE_DLY = 2, compare the undelayed sync against the output -> the output lags by exactly 2 enabled cycles at both the falling and rising edges.
